// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//   - default operand width and Booth step count
//   - step-counter width helper
//   - controller FSM state encoding
package mul_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefSteps = DefWidth / 2;

  // Width of a counter that must hold 0..steps-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  localparam int unsigned DefCntW = cnt_width(DefSteps);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StRun    = 3'd2,
    StSettle = 3'd3,
    StResp   = 3'd4
  } state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Bundle of the requester, response and datapath signals of mul_seq.
//   slave  : the multiplier controller side
//   master : the environment side (requesters, consumer and Booth datapath)
// Signals:
//   req0/1_valid, req0/1_a, req0/1_b  requester operands and valid
//   req0/1_ready                      operands accepted this cycle
//   resp_valid/ready/id/product       product handshake
//   dp_load, dp_step, dp_multiplicand, dp_multiplier, dp_product  datapath control
//   busy                              controller not idle
interface mul_seq_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) ();

  logic               req0_valid;
  logic               req1_valid;
  logic               req0_ready;
  logic               req1_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;

  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic [2*WIDTH-1:0] resp_product;

  logic               dp_load;
  logic               dp_step;
  logic [WIDTH-1:0]   dp_multiplicand;
  logic [WIDTH-1:0]   dp_multiplier;
  logic [2*WIDTH-1:0] dp_product;

  logic               busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_product,
    input  resp_ready,
    output dp_load, dp_step, dp_multiplicand, dp_multiplier,
    input  dp_product,
    output busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_product,
    output resp_ready,
    input  dp_load, dp_step, dp_multiplicand, dp_multiplier,
    output dp_product,
    input  busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst  clock and asynchronous active-high reset
//   valid     request vector, bit n = requester n
//   advance   the current grant is being consumed this cycle
//   grant     one-hot grant (all zero when nobody requests)
//   pointer   requester preferred on contention (0 after reset)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       pointer
);

  logic pointer_q;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Preference moves to whichever requester was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pointer_q <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      pointer_q <= grant[0];
    end
  end

  assign pointer = pointer_q;

endmodule

// File: rtl/mul_seq.sv
// Sequential signed multiplier controller for an external radix-4 Booth datapath.
// Accepts one job at a time from two round-robin arbitrated requesters, loads the
// datapath, runs STEPS Booth steps, captures the product and holds it until taken.
//   clk, rst  clock and asynchronous active-high reset
//   bus       mul_seq_if.slave: requester handshakes, response handshake,
//             datapath control/operands/product and busy
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned STEPS = WIDTH / 2
) (
  input logic      clk,
  input logic      rst,
  mul_seq_if.slave bus
);

  localparam int unsigned     CntW     = cnt_width(STEPS);
  localparam logic [CntW-1:0] LastStep = CntW'(STEPS - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               id_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic               dp_load_q;
  logic               dp_step_q;
  logic               resp_valid_q;
  logic               busy_q;

  logic [1:0] req_valid;
  logic [1:0] grant;
  logic       arb_ptr;
  logic       accept;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  // Ready is combinational so a requester is served in the same cycle it shows
  // valid; it is masked during reset so no handshake can be seen then.
  assign accept = !rst && (state_q == StIdle) && (grant != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .advance (accept),
    .grant   (grant),
    .pointer (arb_ptr)
  );

  assign bus.req0_ready = accept & grant[0];
  assign bus.req1_ready = accept & grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      product_q    <= '0;
      dp_load_q    <= 1'b0;
      dp_step_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            a_q       <= grant[1] ? bus.req1_a : bus.req0_a;
            b_q       <= grant[1] ? bus.req1_b : bus.req0_b;
            dp_load_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          // The arbiter pointer has just moved away from the served requester,
          // so its complement identifies the owner of this job.
          id_q      <= ~arb_ptr;
          dp_load_q <= 1'b0;
          dp_step_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StRun;
        end
        StRun: begin
          if (cnt_q == LastStep) begin
            dp_step_q <= 1'b0;
            state_q   <= StSettle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSettle: begin
          product_q    <= bus.dp_product;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          dp_load_q    <= 1'b0;
          dp_step_q    <= 1'b0;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign bus.dp_load         = dp_load_q;
  assign bus.dp_step         = dp_step_q;
  assign bus.dp_multiplicand = a_q;
  assign bus.dp_multiplier   = b_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_id         = id_q;
  assign bus.resp_product    = product_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: behavioural Booth datapath, reference multiply
// scoreboard, round-robin grant model, timing and reset checks.
module tb_mul_seq;

  localparam int W = 16;
  localparam int S = W / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(W)) bus ();

  mul_seq #(.WIDTH(W), .STEPS(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] outs_vec();
    return {bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.resp_product,
            bus.dp_load, bus.dp_step, bus.dp_multiplicand, bus.dp_multiplier, bus.busy};
  endfunction

  // Reference: plain signed multiplication.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*W-1:0];
  endfunction

  // Behavioural radix-4 Booth datapath: step i adds digit_i * a * 4^i.
  function automatic logic [2*W-1:0] booth_term(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input int i);
    logic [W:0] bx;
    int d;
    longint t;
    bx = {b, 1'b0};
    d = int'(bx[2*i]) + int'(bx[2*i+1]) - 2 * int'(bx[2*i+2]);
    t = longint'(d) * longint'($signed(a));
    t = t <<< (2 * i);
    return t[2*W-1:0];
  endfunction

  logic [W-1:0]   dp_a, dp_b;
  logic [2*W-1:0] dp_acc;
  int             dp_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_acc <= '0; dp_a <= '0; dp_b <= '0; dp_idx <= 0;
    end else if (bus.dp_load) begin
      dp_a <= bus.dp_multiplicand; dp_b <= bus.dp_multiplier; dp_acc <= '0; dp_idx <= 0;
    end else if (bus.dp_step) begin
      dp_acc <= dp_acc + booth_term(dp_a, dp_b, dp_idx);
      dp_idx <= dp_idx + 1;
    end
  end
  assign bus.dp_product = dp_acc;

  // Consumer ready: fixed level or random backpressure.
  logic fix_rdy, rand_en, rnd_rdy;
  always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);
  assign bus.resp_ready = rand_en ? rnd_rdy : fix_rdy;

  typedef struct packed {
    logic           id;
    logic [2*W-1:0] prod;
  } exp_t;
  exp_t exp_q[$];

  int             cyc = 0, acc_cyc = 0, n_steps = 0, n_loads = 0;
  bit             pend = 0, prev_rv = 0, ptr_m = 0;
  logic [W-1:0]   acc_a, acc_b;
  logic [2*W-1:0] last_prod;
  logic           last_id;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("reset_outputs", outs_vec(), '0);
      exp_q.delete();
      ptr_m = 0; pend = 0; prev_rv = 0;
    end else begin
      check("dp_load_step_excl", bus.dp_load & bus.dp_step, 1'b0);
      check("ready_rules", {bus.req0_ready & bus.req1_ready,
                            (bus.req0_ready | bus.req1_ready) & bus.busy}, 2'b00);
      if (!bus.busy && (bus.req0_valid || bus.req1_valid)) begin
        logic gid;
        gid = (bus.req0_valid && bus.req1_valid) ? ptr_m : bus.req1_valid;
        check("grant", {bus.req1_ready, bus.req0_ready}, gid ? 2'b10 : 2'b01);
        if (bus.req0_ready || bus.req1_ready) begin
          gid   = bus.req1_ready;
          acc_a = gid ? bus.req1_a : bus.req0_a;
          acc_b = gid ? bus.req1_b : bus.req0_b;
          exp_q.push_back('{id: gid, prod: ref_mul(acc_a, acc_b)});
          ptr_m = ~gid;
          acc_cyc = cyc; n_steps = 0; n_loads = 0; pend = 1;
        end
      end
      if (bus.dp_load || bus.dp_step) begin
        check("dp_operands", {bus.dp_multiplicand, bus.dp_multiplier}, {acc_a, acc_b});
        if (bus.dp_load) n_loads++;
        if (bus.dp_step) n_steps++;
      end
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", bus.resp_valid, 1'b0);
        end else begin
          check("resp", {bus.resp_id, bus.resp_product}, {exp_q[0].id, exp_q[0].prod});
          if (!prev_rv && pend) begin
            check("latency", cyc - acc_cyc, S + 3);
            check("step_count", n_steps, S);
            check("load_count", n_loads, 1);
            pend = 0;
          end
          if (bus.resp_ready) begin
            last_prod = bus.resp_product;
            last_id   = bus.resp_id;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_rv = bus.resp_valid;
    end
  end

  task automatic set_req(input int who, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    if (who == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic issue(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 0;
    @(posedge clk); #1;
    set_req(who, 1'b1, a, b);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = (who == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check("accept_timeout", got, 1'b1);
    @(posedge clk); #1;
    if (who == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic issue_both(input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input logic [W-1:0] a1, input logic [W-1:0] b1,
                            output int first, output int second);
    int order[$];
    bit d0 = 0, d1 = 0;
    @(posedge clk); #1;
    set_req(0, 1'b1, a0, b0);
    set_req(1, 1'b1, a1, b1);
    for (int n = 0; n < 400 && !(d0 && d1); n++) begin
      @(negedge clk);
      if (bus.req0_valid && bus.req0_ready) begin d0 = 1; order.push_back(0); end
      if (bus.req1_valid && bus.req1_ready) begin d1 = 1; order.push_back(1); end
      @(posedge clk); #1;
      if (d0) bus.req0_valid = 1'b0;
      if (d1) bus.req1_valid = 1'b0;
    end
    check("both_accept_timeout", {d0, d1}, 2'b11);
    first  = (order.size() > 0) ? order[0] : -1;
    second = (order.size() > 1) ? order[1] : -1;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      done = !bus.busy && (exp_q.size() == 0) && !bus.req0_valid && !bus.req1_valid;
    end
    check("idle_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int f, s, k;
    rst = 1'b1; fix_rdy = 1'b1; rand_en = 1'b0;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(0, 16'd3, 16'd5);
    wait_idle();
    check("s1_product", {last_id, last_prod}, {1'b0, 32'h0000000F});

    issue(1, 16'hFFFE, 16'd7);
    wait_idle();
    check("s2_product", {last_id, last_prod}, {1'b1, 32'hFFFFFFF2});

    issue(0, 16'h8000, 16'h8000);
    wait_idle();
    check("s3_product", last_prod, 32'h40000000);

    // Contention straight after reset: req0, then req1, then req0 again.
    do_reset();
    issue_both(16'd11, 16'd13, 16'hFFF0, 16'd3, f, s);
    check("rr_first", f, 0);
    check("rr_second", s, 1);
    wait_idle();
    issue_both(16'd2, 16'd2, 16'd4, 16'd4, f, s);
    check("rr_alternate", f, 0);
    wait_idle();

    // Backpressure: hold the response for 5 cycles with a request pending.
    @(posedge clk); #1 fix_rdy = 1'b0;
    issue(0, 16'h1234, 16'hFEDC);
    k = 0;
    for (int n = 0; n < 50 && !bus.resp_valid; n++) @(negedge clk);
    check("bp_resp_seen", bus.resp_valid, 1'b1);
    set_req(1, 1'b1, 16'h0101, 16'hFF00);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {bus.resp_valid, bus.req1_ready}, 2'b10);
    end
    @(posedge clk); #1 fix_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_after", {bus.busy, bus.req1_ready}, 2'b01);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    wait_idle();

    // Reset in the middle of RUN (counter at 4): job discarded.
    issue(1, 16'h5A5A, 16'h0F0F);
    k = 0;
    for (int n = 0; n < 50 && k < 5; n++) begin
      @(negedge clk);
      if (bus.dp_step) k++;
    end
    #2 rst = 1'b1;
    #1 check("rst_immediate", outs_vec(), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_resp_after_rst", bus.resp_valid, 1'b0);
    issue(0, 16'd100, 16'hFFFD);
    wait_idle();
    check("post_rst_product", last_prod, 32'hFFFFFED4);

    // Random traffic with random backpressure.
    rand_en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      case ($urandom_range(0, 2))
        0: issue(0, rnd_op(), rnd_op());
        1: issue(1, rnd_op(), rnd_op());
        default: issue_both(rnd_op(), rnd_op(), rnd_op(), rnd_op(), f, s);
      endcase
    end
    wait_idle();
    rand_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, 16, operand width in bits, even and at least 4.
REQ-002 SHALL have parameter STEPS, WIDTH/2, number of radix-4 Booth step cycles.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous and active-high.
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  requester n presents operands.
REQ-006 SHALL have ports req0_ready / req1_ready  out  1  requester n operands accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  in  WIDTH  two's-complement multiplicand (a) and multiplier (b).
REQ-008 SHALL have port resp_valid  out  1  product available.
REQ-009 SHALL have port resp_ready  in  1  consumer accepts product.
REQ-010 SHALL have port resp_id  out  1  requester that owns the product.
REQ-011 SHALL have port resp_product  out  2*WIDTH  signed product.
REQ-012 SHALL have port dp_load  out  1  one-cycle pulse that loads the datapath shift register.
REQ-013 SHALL have ports dp_multiplicand, dp_multiplier  out  WIDTH  operands driven to the datapath.
REQ-014 SHALL have port dp_step  out  1  datapath performs one Booth add/shift this cycle.
REQ-015 SHALL have port dp_product  in  2*WIDTH  datapath accumulated product.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, SETTLE, RESP.
REQ-018 IDLE: if any reqN_valid is high, SHALL assert only the granted reqN_ready, latch that requester's a, b and id, and move to LOAD.
REQ-019 Arbitration SHALL grant the single valid requester whenever only one is valid; when both are valid, it SHALL grant the requester indicated by the round-robin pointer.
REQ-020 The pointer SHALL move to the non-granted requester on each accept; it SHALL reset to 0 (req0 preferred).
REQ-021 reqN_ready SHALL be 0 in every state except IDLE; at most one ready SHALL be high per cycle.
REQ-022 LOAD: SHALL assert dp_load for exactly 1 cycle, drive the latched operands on dp_multiplicand and dp_multiplier, clear the step counter, and move to RUN.
REQ-023 RUN: SHALL assert dp_step for exactly STEPS consecutive cycles, with the counter running 0..STEPS-1, and move to SETTLE after the last step.
REQ-024 SETTLE: SHALL register dp_product into the result register, with dp_step and dp_load low, and move to RESP.
REQ-025 RESP: SHALL hold resp_valid=1 with resp_product and resp_id stable until resp_valid && resp_ready; on that handshake it SHALL return to IDLE.
REQ-026 Latency: resp_valid SHALL rise exactly STEPS+3 cycles after the accepting edge (11 for WIDTH=16).
REQ-027 Minimum accept-to-accept spacing SHALL be STEPS+4 cycles with resp_ready held high; there is no overlap of jobs.
REQ-028 dp_multiplicand and dp_multiplier SHALL stay stable from LOAD through SETTLE.
REQ-029 dp_load and dp_step SHALL never be high in the same cycle.
REQ-030 A reqN_valid that drops before being granted SHALL leave no effect.

Reset
REQ-031 rst high SHALL immediately force IDLE, pointer=0 and counter=0.
REQ-032 During reset, all ready, valid, dp_load, dp_step and busy outputs SHALL be 0, and resp_product, resp_id and dp operands SHALL be 0.
REQ-033 A reset asserted mid-job (LOAD/RUN/SETTLE/RESP) SHALL discard the job; no resp_valid SHALL follow.

Structure
REQ-034 Shared package mul_pkg SHALL hold the FSM state encoding, WIDTH and STEPS defaults, and the step-counter width ($clog2(STEPS)).
REQ-035 The two-requester round-robin arbiter SHALL be a sub-module rr_arb2 (inputs valid[1:0] and advance; outputs grant one-hot and pointer); all other logic SHALL live in mul_seq.

Verification
REQ-036 Scenario: req0 a=3, b=5 -> req0_ready 1 cycle, dp_load 1 cycle, dp_step 8 cycles, resp_valid at +11 cycles, resp_product=0x0000000F, resp_id=0.
REQ-037 Scenario: req1 a=-2 (0xFFFE), b=7 -> resp_product=0xFFFFFFF2, resp_id=1.
REQ-038 Scenario: a=b=0x8000 -> resp_product=0x40000000.
REQ-039 Scenario: both valid after reset, resp_ready=1 -> req0 served first, then req1; next contention -> req0 again (alternation).
REQ-040 Scenario: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_product and resp_id stable; reqN_ready=0 throughout; IDLE the cycle after resp_ready=1.
REQ-041 Scenario: rst pulsed at RUN step 4 -> all outputs 0 at once, no response, and a new request accepted normally afterwards.
REQ-042 The bench SHALL use a behavioural radix-4 Booth datapath model connected to the dp_* ports, and SHALL assert REQ-021 and REQ-029 every cycle.
